// File: rtl/bw_mult_pkg.sv
// Shared types and helpers for the round-robin Baugh-Wooley multiplier arbiter.
// Optional output register stage is selected by BW_MULT_OUT_REG_EN.
package bw_mult_pkg;

  localparam int OP_W    = 4;
  localparam int RES_W   = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // First valid index at or after ptr, searching cyclically over n slots.
  function automatic logic [2:0] rr_pick(
    input logic [MAX_REQ-1:0] vld,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [2:0] g;
    logic       hit;
    int         idx;
    g   = '0;
    hit = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!hit && i < n && vld[idx]) begin
        g   = 3'(idx);
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/baugh_wooley_multiplier_4_bit.sv
// Combinational 4x4 signed multiplier, Baugh-Wooley partial-product form.
// Sign-row terms are inverted and the 2^4 + 2^7 correction is pre-loaded.
module baugh_wooley_multiplier_4_bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);

  always_comb begin
    z = 8'h90;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        z = z + ({7'b0, x[i] & y[j]} << (i + j));
      end
    end
    z = z + ({7'b0, x[3] & y[3]} << 6);
    for (int i = 0; i < 3; i++) begin
      z = z + ({7'b0, ~(x[i] & y[3])} << (i + 3));
      z = z + ({7'b0, ~(x[3] & y[i])} << (i + 3));
    end
  end

endmodule

// File: rtl/bw_mult_arbiter.sv
// Round-robin sequencer sharing one 4-bit signed multiplier among requesters.
// Define BW_MULT_OUT_REG_EN to register the multiplier output (adds WAIT).
module bw_mult_arbiter
  import bw_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_x,
  input  logic [OP_W*NUM_REQ-1:0] req_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_z
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [OP_W-1:0]  op_x_q, op_x_d;
  logic [OP_W-1:0]  op_y_q, op_y_d;
  logic [RES_W-1:0] rsp_z_q, rsp_z_d;
  logic [RES_W-1:0] z;
  logic [ID_W-1:0]  grant;
  logic             any;
`ifdef BW_MULT_OUT_REG_EN
  logic [RES_W-1:0] pipe_q, pipe_d;
`endif

  baugh_wooley_multiplier_4_bit u_mul (
    .x (op_x_q),
    .y (op_y_q),
    .z (z)
  );

  always_comb begin
    any       = |req_valid;
    grant     = ID_W'(rr_pick(8'(req_valid), 3'(ptr_q), NUM_REQ));
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    rsp_z_d   = rsp_z_q;
    req_ready = '0;
`ifdef BW_MULT_OUT_REG_EN
    pipe_d    = pipe_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          req_ready[grant] = 1'b1;
          op_x_d  = req_x[grant*OP_W +: OP_W];
          op_y_d  = req_y[grant*OP_W +: OP_W];
          id_d    = grant;
          ptr_d   = ID_W'((int'(grant) + 1) % NUM_REQ);
          state_d = MUL;
        end
      end
      MUL: begin
`ifdef BW_MULT_OUT_REG_EN
        pipe_d  = z;
        state_d = WAIT;
`else
        rsp_z_d = z;
        state_d = RESP;
`endif
      end
      WAIT: begin
`ifdef BW_MULT_OUT_REG_EN
        rsp_z_d = pipe_q;
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing may be granted while reset is being applied.
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_x_q  <= '0;
      op_y_q  <= '0;
      rsp_z_q <= '0;
`ifdef BW_MULT_OUT_REG_EN
      pipe_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      rsp_z_q <= rsp_z_d;
`ifdef BW_MULT_OUT_REG_EN
      pipe_q  <= pipe_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_bw_mult_arbiter.sv
// Self-checking bench for bw_mult_arbiter against a queue/arithmetic model.
// Honours BW_MULT_OUT_REG_EN for the expected latency.
module tb_bw_mult_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef BW_MULT_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int         id;
    logic [7:0] z;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_x = '0;
  logic [4*N-1:0] req_y = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_z;

  int cmp = 0;
  int bad = 0;
  int mptr = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bw_mult_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z)
  );

  function automatic logic [7:0] golden(input logic [3:0] x, input logic [3:0] y);
    int a;
    int b;
    a = $signed(x);
    b = $signed(y);
    return 8'(a * b);
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); bad++;
    end
    cmp++;
    if (rsp_z !== 8'h00) begin
      $display("FAIL reset_rsp_z got %h want 00", rsp_z); bad++;
    end
    cmp++;
    if (rsp_id !== '0) begin
      $display("FAIL reset_rsp_id got %0d want 0", rsp_id); bad++;
    end
    cmp++;
    if (req_ready !== '0) begin
      $display("FAIL reset_req_ready got %b want 0", req_ready); bad++;
    end
    mptr = 0;
  endtask

  task automatic single(input int id, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] ez,
                        input string nm);
    logic [N-1:0] er;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_x[4*id +: 4] = x;
    req_y[4*id +: 4] = y;
    rsp_ready = 1'b1;
    #1;
    er = '0;
    er[model_grant(req_valid, mptr)] = 1'b1;
    cmp++;
    if (req_ready !== er) begin
      $display("FAIL %s_ready got %b want %b", nm, req_ready, er); bad++;
    end
    tick();
    req_valid = '0;
    mptr = (id + 1) % N;
    for (int k = 0; k < LAT - 1; k++) begin
      #1;
      cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
        $display("FAIL %s_early got v=%0b r=%b want 0/0", nm, rsp_valid, req_ready);
        bad++;
      end
      tick();
    end
    cmp++;
    if (rsp_valid !== 1'b1 || rsp_z !== ez || rsp_id !== IW'(id)) begin
      $display("FAIL %s_rsp got v=%0b z=%h id=%0d want 1 %h %0d",
               nm, rsp_valid, rsp_z, rsp_id, ez, id);
      bad++;
    end
    tick();
    cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL %s_done got v=%0b want 0", nm, rsp_valid); bad++;
    end
  endtask

  task automatic test_directed();
    single(1, 4'd3, 4'd5, 8'h0F, "r1_3x5");
    single(0, 4'h8, 4'h8, 8'h40, "r0_m8xm8");
    single(2, 4'h8, 4'h7, 8'hC8, "r2_m8x7");
    single(3, 4'hF, 4'h1, 8'hFF, "r3_m1x1");
  endtask

  task automatic test_rotation();
    exp_t q[$];
    exp_t e;
    int   grants;
    int   last;
    int   g;
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    mptr = 0;
    rsp_ready = 1'b1;
    req_x = 16'($urandom);
    req_y = 16'($urandom);
    req_valid = '1;
    grants = 0;
    last = 0;
    #1;
    for (int c = 0; c < 60 && grants < 5; c++) begin
      if (rsp_valid) begin
        cmp++;
        if (q.size() == 0) begin
          $display("FAIL rot_spurious got z=%h want none", rsp_z); bad++;
        end else begin
          e = q.pop_front();
          if (rsp_z !== e.z || rsp_id !== IW'(e.id)) begin
            $display("FAIL rot_rsp got z=%h id=%0d want %h %0d",
                     rsp_z, rsp_id, e.z, e.id);
            bad++;
          end
        end
      end
      cmp++;
      if ($countones(req_ready) > 1) begin
        $display("FAIL rot_onehot got %b want one-hot or zero", req_ready); bad++;
      end
      g = -1;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        cmp++;
        if (g != model_grant(req_valid, mptr) || g != grants % N) begin
          $display("FAIL rot_order got %0d want %0d", g, grants % N); bad++;
        end
        if (grants > 0) begin
          cmp++;
          if (cyc - last != LAT + 1) begin
            $display("FAIL rot_spacing got %0d want %0d", cyc - last, LAT + 1);
            bad++;
          end
        end
        e.id = g;
        e.z = golden(req_x[4*g +: 4], req_y[4*g +: 4]);
        q.push_back(e);
        mptr = (g + 1) % N;
        last = cyc;
        grants++;
      end
      tick();
      if (g >= 0) begin
        req_x[4*g +: 4] = 4'($urandom);
        req_y[4*g +: 4] = 4'($urandom);
      end
      #1;
    end
    cmp++;
    if (grants < 5) begin
      $display("FAIL rot_timeout got %0d grants want 5", grants); bad++;
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid && q.size() > 0) begin
        e = q.pop_front();
        cmp++;
        if (rsp_z !== e.z || rsp_id !== IW'(e.id)) begin
          $display("FAIL rot_drain got z=%h id=%0d want %h %0d",
                   rsp_z, rsp_id, e.z, e.id);
          bad++;
        end
      end
      tick();
    end
    cmp++;
    if (q.size() != 0) begin
      $display("FAIL rot_lost got %0d pending want 0", q.size()); bad++;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] er;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_valid[2] = 1'b1;
    req_x[11:8] = 4'h8;
    req_y[11:8] = 4'h7;
    #1;
    er = '0;
    er[model_grant(req_valid, mptr)] = 1'b1;
    cmp++;
    if (req_ready !== er) begin
      $display("FAIL bp_ready got %b want %b", req_ready, er); bad++;
    end
    tick();
    mptr = 3;
    req_valid = '0;
    req_valid[0] = 1'b1;
    req_x[3:0] = 4'h8;
    req_y[3:0] = 4'h8;
    for (int k = 0; k < LAT - 1; k++) tick();
    for (int k = 0; k < 6; k++) begin
      cmp++;
      if (rsp_valid !== 1'b1 || rsp_z !== 8'hC8 || rsp_id !== 2'd2 ||
          req_ready !== '0) begin
        $display("FAIL bp_hold got v=%0b z=%h id=%0d r=%b want 1 c8 2 0",
                 rsp_valid, rsp_z, rsp_id, req_ready);
        bad++;
      end
      if (k < 5) tick();
    end
    rsp_ready = 1'b1;
    #1;
    cmp++;
    if (req_ready !== '0) begin
      $display("FAIL bp_hs_ready got %b want 0", req_ready); bad++;
    end
    tick();
    er = '0;
    er[model_grant(req_valid, mptr)] = 1'b1;
    cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== er) begin
      $display("FAIL bp_next got v=%0b r=%b want 0 %b", rsp_valid, req_ready, er);
      bad++;
    end
    tick();
    req_valid = '0;
    mptr = 1;
    for (int k = 0; k < LAT - 1; k++) tick();
    cmp++;
    if (rsp_valid !== 1'b1 || rsp_z !== 8'h40 || rsp_id !== 2'd0) begin
      $display("FAIL bp_second got v=%0b z=%h id=%0d want 1 40 0",
               rsp_valid, rsp_z, rsp_id);
      bad++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    single(1, 4'd7, 4'd7, golden(4'd7, 4'd7), "pre_rst");
    req_valid = '0;
    req_valid[1] = 1'b1;
    req_x[7:4] = 4'd3;
    req_y[7:4] = 4'd3;
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    cmp++;
    if (rsp_valid !== 1'b0 || rsp_z !== 8'h00 || rsp_id !== '0 ||
        req_ready !== '0) begin
      $display("FAIL midrst_out got v=%0b z=%h id=%0d r=%b want 0 00 0 0",
               rsp_valid, rsp_z, rsp_id, req_ready);
      bad++;
    end
    rst_n = 1'b1;
    mptr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cmp++;
      if (rsp_valid !== 1'b0) begin
        $display("FAIL midrst_ghost got v=%0b want 0", rsp_valid); bad++;
      end
    end
    req_valid = '1;
    #1;
    cmp++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL midrst_ptr got %b want 0001", req_ready); bad++;
    end
    tick();
    req_valid = '0;
    mptr = 1;
    for (int k = 0; k < LAT; k++) tick();
  endtask

  task automatic test_sweep();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        single(N - 1, 4'(x), 4'(y), golden(4'(x), 4'(y)), "sweep");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/bw_mult_arbiter.md
# bw_mult_arbiter

Round-robin arbiter and sequencer that shares one combinational 4-bit signed Baugh-Wooley multiplier among NUM_REQ requesters. Each requester hands over a signed operand pair through a valid/ready handshake. The block registers the operands, drives the shared multiplier, captures the product, and returns it with the requester ID through a single valid/ready response port. It sits between the multiplier core and the client logic in the arithmetic subsystem.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of rsp_id
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_x  in  4*NUM_REQ  signed multiplicand; requester i uses bits [4i+3:4i]
- req_y  in  4*NUM_REQ  signed multiplier; same packing as req_x
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  ID_W  index of the requester that owns rsp_z
- rsp_z  out  8  signed product x*y, two's complement

## Operation
- FSM states: IDLE, MUL, WAIT (present only with the macro), RESP.
- IDLE:
  - If any req_valid is high, grant g, the first valid index at or after ptr, searching cyclically.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: op_x <= req_x[g], op_y <= req_y[g], id <= g, ptr <= (g+1) mod NUM_REQ, next state MUL.
  - If no request is valid, stay in IDLE; ptr is unchanged.
- MUL: op_x/op_y drive the multiplier core.
  - Without the macro: rsp_z <= z, next state RESP.
  - With the macro: z is captured into an internal pipeline register, next state WAIT.
- WAIT: rsp_z <= pipeline register, next state RESP.
- RESP:
  - rsp_valid=1; rsp_z and rsp_id are held stable.
  - On rsp_valid && rsp_ready, next state IDLE.
  - No new request is accepted in RESP, even when the response handshake completes in that cycle.
- req_ready is 0 in every state except IDLE.
- A requester must hold req_valid, req_x and req_y stable until it sees ready. Dropping valid before grant is legal and has no side effect.
- Arithmetic: full-precision signed 4x4 product, range -56..+64, always exact in 8 bits. -8*-8 = 0x40.
- Only one transaction is in flight at a time. The block has no queue.

## Timing
- Reset values: rsp_valid=0, rsp_z=0, rsp_id=0, req_ready=0, state=IDLE, ptr=0, op_x=op_y=0.
- Accept edge at cycle T: rsp_valid is high from T+2 without the macro, from T+3 with it.
- Minimum spacing between accepts: 3 cycles without the macro, 4 with it, with rsp_ready held high.
- Backpressure: while rsp_ready=0, the FSM stays in RESP indefinitely with outputs frozen.
- Reset mid-operation: the in-flight transaction is discarded, all outputs return to reset values on the next edge, and no response is produced.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,NUM_REQ-1,0,...

## Configuration
- BW_MULT_OUT_REG_EN defined:
  - Adds a register stage on the multiplier output and the WAIT state.
  - Latency is +1 cycle; the path from the multiplier to rsp_z becomes register-to-register.
- BW_MULT_OUT_REG_EN undefined:
  - The multiplier output is captured straight into rsp_z.
  - The WAIT state encoding is unused and unreachable.

## Structure
- Package bw_mult_pkg holds:
  - OP_W=4, RES_W=8
  - state enum typedef (IDLE, MUL, WAIT, RESP)
  - a function that computes the round-robin next-grant index
- Sub-module: one instance of baugh_wooley_multiplier_4_bit (x=op_x, y=op_y, z), unmodified.
- Everything else is local to bw_mult_arbiter: FSM, pointer, operand/ID registers, optional pipeline register.

## Test plan
- Reset, then a single request on requester 1 with x=3, y=5 -> accepted in 1 cycle; rsp_valid at T+2 with rsp_z=0x0F, rsp_id=1.
- Requester 0 with x=-8, y=-8 -> rsp_z=0x40. Requester 2 with x=-8, y=7 -> rsp_z=0xC8. Requester 3 with x=-1, y=1 -> rsp_z=0xFF.
- All 4 requesters valid continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0, one accept every 3 cycles (4 with BW_MULT_OUT_REG_EN), req_ready always one-hot or zero.
- Product ready with rsp_ready held low for 5 cycles -> rsp_valid, rsp_z and rsp_id stay constant, req_ready stays 0; the next accept occurs only after the response handshake.
- rst_n asserted in the MUL state -> next cycle rsp_valid=0, rsp_z=0, ptr=0, and no response ever appears for the dropped operation.
- Exhaustive sweep of all 256 x,y pairs via requester NUM_REQ-1 -> every rsp_z equals the signed x*y golden value, under both macro settings.
